// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 transmitter between NUM_REQ message sources.
// Optional stall timeout in LOAD is enabled by defining UART_ARB_TIMEOUT_EN (adds timeout_o).
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o,
  output logic [7:0]           tx_data_o,
  output logic                 tx_start_o,
`ifdef UART_ARB_TIMEOUT_EN
  output logic                 timeout_o,
`endif
  input  logic                 tx_done_i
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LOAD      = 2'd1;
  localparam logic [1:0] S_WAIT_ACK  = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  if (NUM_REQ < 1 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("uart_tx_arbiter: NUM_REQ must be 1..16 and TIMEOUT_CYCLES at least 1");
  end

  logic [1:0]         state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   grant_idx;
  logic               last_q;

  logic [NUM_REQ-1:0] rot_valid;
  logic [PTR_W:0]     scan_sum;
  logic               pick_found;
  logic [PTR_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;

  logic               g_valid;
  logic [7:0]         g_data;
  logic               g_last;
  logic               accept;
  logic [PTR_W-1:0]   ptr_after_grant;

  // Rotating the valid vector by rr_ptr turns the round-robin scan into a
  // plain first-set-bit search; the offset is then mapped back to an index.
  always_comb begin
    rot_valid   = NUM_REQ'({req_valid_i, req_valid_i} >> rr_ptr);
    pick_found  = 1'b0;
    scan_sum    = '0;
    pick_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_found && rot_valid[i]) begin
        pick_found = 1'b1;
        scan_sum   = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      end
    end
    if (scan_sum >= (PTR_W+1)'(NUM_REQ)) begin
      scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
    end
    pick_idx = scan_sum[PTR_W-1:0];
    for (int k = 0; k < NUM_REQ; k++) begin
      pick_onehot[k] = (pick_idx == PTR_W'(k));
    end
  end

  always_comb begin
    g_valid = 1'b0;
    g_data  = 8'h00;
    g_last  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_o[k]) begin
        g_valid = req_valid_i[k];
        g_data  = req_data_i[8*k +: 8];
        g_last  = req_last_i[k];
      end
    end
  end

  assign req_ready_o     = (state == S_LOAD && tx_done_i) ? grant_o : '0;
  assign accept          = (state == S_LOAD) && tx_done_i && g_valid;
  assign busy_o          = (state != S_IDLE);
  assign ptr_after_grant = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + PTR_W'(1);

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [CNT_W-1:0] stall_cnt;
  logic             timeout_hit;

  assign timeout_hit = (state == S_LOAD) && !g_valid &&
                       (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // The counter idles at zero outside LOAD, which gives the clear-on-entry behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= timeout_hit;
      if (state != S_LOAD || accept || timeout_hit) begin
        stall_cnt <= '0;
      end else if (!g_valid) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end
`endif

  // The grant is held across LOAD/WAIT states until the last byte's done rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      grant_o    <= '0;
      grant_idx  <= '0;
      tx_data_o  <= 8'h00;
      tx_start_o <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      tx_start_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            grant_o   <= pick_onehot;
            grant_idx <= pick_idx;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (accept) begin
            tx_data_o  <= g_data;
            tx_start_o <= 1'b1;
            last_q     <= g_last;
            state      <= S_WAIT_ACK;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (timeout_hit) begin
            grant_o <= '0;
            rr_ptr  <= ptr_after_grant;
            state   <= S_IDLE;
          end
`endif
        end
        S_WAIT_ACK: begin
          if (!tx_done_i) begin
            state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (tx_done_i) begin
            if (last_q) begin
              grant_o <= '0;
              rr_ptr  <= ptr_after_grant;
              state   <= S_IDLE;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: queued messages per requester, a simple
// transmitter model, and a round-robin message-order reference model.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;

  logic                 clk;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid_i;
  logic [8*NUM_REQ-1:0] req_data_i;
  logic [NUM_REQ-1:0]   req_last_i;
  logic [NUM_REQ-1:0]   req_ready_o;
  logic [NUM_REQ-1:0]   grant_o;
  logic                 busy_o;
  logic [7:0]           tx_data_o;
  logic                 tx_start_o;
  logic                 tx_done_i;
`ifdef UART_ARB_TIMEOUT_EN
  logic                 timeout_o;
`endif

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid_i(req_valid_i),
    .req_data_i(req_data_i),
    .req_last_i(req_last_i),
    .req_ready_o(req_ready_o),
    .grant_o(grant_o),
    .busy_o(busy_o),
    .tx_data_o(tx_data_o),
    .tx_start_o(tx_start_o),
`ifdef UART_ARB_TIMEOUT_EN
    .timeout_o(timeout_o),
`endif
    .tx_done_i(tx_done_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;
  int n_starts;

  logic [8:0] req_q [NUM_REQ][$];
  logic [8:0] mdl_q [NUM_REQ][$];
  logic [9:0] exp_q [$];
  int         model_ptr;

  int stall_left [NUM_REQ];
  int stall_age;
  int stall_prob;
  int stall_max;
  int force_stall;

  bit tx_model_en;
  bit drop_pending;
  int tx_timer;
  int tx_len_min;
  int tx_len_max;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] assertion on %s", tag);
    end
  endtask

  task automatic push_byte(input int k, input logic [7:0] b, input bit last);
    req_q[k].push_back({last, b});
    mdl_q[k].push_back({last, b});
  endtask

  task automatic push_msg_random(input int k, input int len);
    for (int j = 0; j < len; j++) push_byte(k, 8'($urandom), (j == len - 1));
  endtask

  function automatic int pending_bytes();
    int s = 0;
    for (int k = 0; k < NUM_REQ; k++) s += req_q[k].size();
    return s;
  endfunction

  // Reference: whole messages leave in round-robin order starting at the pointer,
  // and the pointer moves just past whoever finished.
  task automatic build_expected();
    int k;
    bit more;
    bit msg_end;
    logic [8:0] e;
    more = 1'b1;
    while (more) begin
      k = -1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (k < 0 && mdl_q[(model_ptr + i) % NUM_REQ].size() > 0) k = (model_ptr + i) % NUM_REQ;
      end
      if (k < 0) begin
        more = 1'b0;
      end else begin
        msg_end = 1'b0;
        while (!msg_end) begin
          e = mdl_q[k].pop_front();
          exp_q.push_back({2'(k), e[7:0]});
          msg_end = e[8] || (mdl_q[k].size() == 0);
        end
        model_ptr = (k + 1) % NUM_REQ;
      end
    end
  endtask

  task automatic refresh_drive();
    logic [8:0] w;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_q[k].size() > 0 && stall_left[k] == 0) begin
        w = req_q[k][0];
        req_valid_i[k]           = 1'b1;
        req_data_i[8*k +: 8]     = w[7:0];
        req_last_i[k]            = w[8];
      end else begin
        req_valid_i[k]           = 1'b0;
        req_data_i[8*k +: 8]     = 8'($urandom);
        req_last_i[k]            = 1'($urandom);
      end
    end
  endtask

  task automatic tx_step();
    if (tx_model_en) begin
      if (drop_pending) begin
        tx_done_i    = 1'b0;
        tx_timer     = $urandom_range(tx_len_max, tx_len_min);
        drop_pending = 1'b0;
      end else if (tx_timer > 0) begin
        tx_timer--;
        if (tx_timer == 0) tx_done_i = 1'b1;
      end
      if (tx_start_o === 1'b1) drop_pending = 1'b1;
    end
  endtask

  task automatic applyStimulus(input int budget, input string tag);
    int cyc;
    logic [NUM_REQ-1:0] acc;
    logic [9:0] e;
    logic [8:0] popped;
    cyc = 0;
    n_starts = 0;
    refresh_drive();
    while ((pending_bytes() > 0 || exp_q.size() > 0 || tx_done_i !== 1'b1 || busy_o !== 1'b0 ||
            tx_timer > 0 || drop_pending) && cyc < budget) begin
      @(negedge clk);
      if (tx_start_o === 1'b1) begin
        n_starts++;
        checkOutput({tag, "_start_expected"}, 32'(exp_q.size() > 0), 1);
        checkOutput({tag, "_start_done_high"}, 32'(tx_done_i), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checkOutput({tag, "_tx_data"}, 32'(tx_data_o), 32'(e[7:0]));
          checkOutput({tag, "_grant_at_start"}, 32'(grant_o), 32'(1) << e[9:8]);
        end
      end
      checkOutput({tag, "_ready_only_granted"}, 32'(req_ready_o & ~grant_o), 0);
      for (int k = 0; k < NUM_REQ; k++) begin
        if (stall_left[k] > 0 && stall_age >= 1) begin
          checkOutput({tag, "_stall_grant_held"}, 32'(grant_o), 32'(1) << k);
          checkOutput({tag, "_stall_no_start"}, 32'(tx_start_o), 0);
        end
      end
      acc = req_valid_i & req_ready_o;
      @(posedge clk);
      #1;
      stall_age++;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (acc[k]) begin
          popped = req_q[k].pop_front();
          if (!popped[8] && req_q[k].size() > 0) begin
            if (force_stall > 0) begin
              stall_left[k] = force_stall;
              force_stall   = 0;
              stall_age     = 0;
            end else if ($urandom_range(99, 0) < stall_prob) begin
              stall_left[k] = $urandom_range(stall_max, 1);
              stall_age     = 0;
            end
          end
        end else if (stall_left[k] > 0) begin
          stall_left[k]--;
        end
      end
      tx_step();
      refresh_drive();
      cyc++;
    end
    checkOutput({tag, "_finished_in_budget"}, 32'(cyc < budget), 1);
    checkOutput({tag, "_all_bytes_seen"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    n_starts = 0;
    rst_n = 1'b0;
    tx_done_i = 1'b1;
    req_valid_i = '0;
    req_data_i = '0;
    req_last_i = '0;
    model_ptr = 0;
    stall_age = 0;
    stall_prob = 0;
    stall_max = 1;
    force_stall = 0;
    tx_model_en = 1'b1;
    drop_pending = 1'b0;
    tx_timer = 0;
    for (int k = 0; k < NUM_REQ; k++) stall_left[k] = 0;

    $display("[TB] reset values");
    repeat (3) @(negedge clk);
    checkOutput("rst_grant", 32'(grant_o), 0);
    checkOutput("rst_ready", 32'(req_ready_o), 0);
    checkOutput("rst_busy", 32'(busy_o), 0);
    checkOutput("rst_tx_data", 32'(tx_data_o), 0);
    checkOutput("rst_tx_start", 32'(tx_start_o), 0);
`ifdef UART_ARB_TIMEOUT_EN
    checkOutput("rst_timeout", 32'(timeout_o), 0);
`endif
    rst_n = 1'b1;

    $display("[TB] single requester, two bytes");
    tx_len_min = 100;
    tx_len_max = 100;
    push_byte(2, 8'h41, 1'b0);
    push_byte(2, 8'h42, 1'b1);
    build_expected();
    applyStimulus(1000, "single");
    checkOutput("single_two_starts", 32'(n_starts), 2);
    checkOutput("single_grant_released", 32'(grant_o), 0);
    checkOutput("single_idle", 32'(busy_o), 0);

    tx_len_min = 2;
    tx_len_max = 12;
    push_msg_random(3, 1);
    build_expected();
    applyStimulus(500, "align");

    $display("[TB] contention 0,1,3");
    push_msg_random(0, 3);
    push_msg_random(1, 3);
    push_msg_random(3, 3);
    build_expected();
    applyStimulus(1500, "contend");
    checkOutput("contend_grant_released", 32'(grant_o), 0);

    $display("[TB] fairness after finish");
    push_msg_random(0, 2);
    push_msg_random(0, 1);
    push_msg_random(1, 1);
    build_expected();
    applyStimulus(1000, "fair");

`ifndef UART_ARB_TIMEOUT_EN
    $display("[TB] long mid-message stall");
    push_msg_random(1, 3);
    push_msg_random(2, 2);
    force_stall = 50;
    build_expected();
    applyStimulus(2000, "stall");
`endif

    $display("[TB] randomized rounds");
    stall_prob = 25;
    stall_max = 6;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int nmsg = $urandom_range(2, 0);
        for (int m = 0; m < nmsg; m++) push_msg_random(k, $urandom_range(4, 1));
      end
      if (pending_bytes() == 0) push_msg_random($urandom_range(NUM_REQ - 1, 0), 1);
      build_expected();
      applyStimulus(5000, "random");
      checkOutput("random_grant_released", 32'(grant_o), 0);
    end
    stall_prob = 0;

    $display("[TB] reset during WAIT_DONE");
    tx_model_en = 1'b0;
    tx_done_i = 1'b1;
    @(negedge clk);
    req_valid_i = 4'b0001;
    req_data_i = 32'h0000_0055;
    req_last_i = 4'b0000;
    begin
      int w = 0;
      while (tx_start_o !== 1'b1 && w < 10) begin
        @(negedge clk);
        w++;
      end
    end
    checkOutput("midrst_first_start", 32'(tx_start_o), 1);
    req_valid_i = '0;
    @(posedge clk);
    #1 tx_done_i = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("midrst_busy_before", 32'(busy_o), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_grant", 32'(grant_o), 0);
    checkOutput("midrst_busy", 32'(busy_o), 0);
    checkOutput("midrst_start", 32'(tx_start_o), 0);
    checkOutput("midrst_ready", 32'(req_ready_o), 0);
    checkOutput("midrst_data", 32'(tx_data_o), 0);
    model_ptr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    req_valid_i = 4'b0001;
    req_data_i = 32'h0000_0066;
    req_last_i = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("postrst_ready_low", 32'(req_ready_o), 0);
      checkOutput("postrst_start_low", 32'(tx_start_o), 0);
    end
    checkOutput("postrst_grant", 32'(grant_o), 32'h1);
    tx_done_i = 1'b1;
    #1;
    checkOutput("postrst_ready_high", 32'(req_ready_o), 32'h1);
    @(posedge clk);
    #1;
    req_valid_i = '0;
    checkOutput("postrst_start", 32'(tx_start_o), 1);
    checkOutput("postrst_data", 32'(tx_data_o), 32'h66);
    @(posedge clk);
    #1;
    checkOutput("postrst_start_one_cycle", 32'(tx_start_o), 0);
    tx_done_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 tx_done_i = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("postrst_released", 32'(grant_o), 0);
    checkOutput("postrst_idle", 32'(busy_o), 0);
    model_ptr = 1;

`ifdef UART_ARB_TIMEOUT_EN
    $display("[TB] timeout on stalled grant");
    @(negedge clk);
    req_valid_i = 4'b0001;
    req_last_i = 4'b0000;
    @(posedge clk);
    #1;
    req_valid_i = 4'b0010;
    req_data_i = 32'h0000_7700;
    req_last_i = 4'b0010;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      checkOutput("timeout_not_yet", 32'(timeout_o), 0);
      checkOutput("timeout_grant_held", 32'(grant_o), 32'h1);
    end
    @(negedge clk);
    checkOutput("timeout_pulse", 32'(timeout_o), 1);
    checkOutput("timeout_grant_cleared", 32'(grant_o), 0);
    @(negedge clk);
    checkOutput("timeout_pulse_end", 32'(timeout_o), 0);
    checkOutput("timeout_next_grant", 32'(grant_o), 32'h2);
    req_valid_i = '0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one 8N1 serial transmitter between NUM_REQ requesters, for example a debug printer, a telemetry streamer and a command echo path.
- Each requester offers bytes over a valid/ready interface with a last flag.
- The arbiter grants one requester round-robin and holds the grant until that requester's last byte has fully left the transmitter, so messages never interleave.
- It drives the transmitter's start/data inputs and watches its done output.

Parameters:
NUM_REQ, 4, number of requesters; legal range 1..16.
TIMEOUT_CYCLES, 1024, stall limit in clk cycles; used only when UART_ARB_TIMEOUT_EN is defined.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
req_valid_i  input  NUM_REQ  per-requester byte valid.
req_data_i  input  8*NUM_REQ  per-requester byte; requester k uses bits [8k+7:8k].
req_last_i  input  NUM_REQ  marks the final byte of a requester's message; sampled with that byte.
req_ready_o  output  NUM_REQ  byte accepted when valid and ready are both high; at most one bit high.
grant_o  output  NUM_REQ  one-hot current owner; all zero when idle.
busy_o  output  1  high whenever state is not IDLE.
tx_data_o  output  8  byte to the transmitter; holds its value until the next accepted byte.
tx_start_o  output  1  single-cycle start pulse to the transmitter.
tx_done_i  input  1  transmitter idle/done flag; high when a new start may be issued.

Behaviour:
- Reset values: req_ready_o=0, grant_o=0, tx_data_o=0, tx_start_o=0, busy_o=0, rr_ptr=0, state=IDLE. Reset takes effect immediately, including mid-message; any byte in flight in the transmitter is not tracked.
- rr_ptr width is max(1,$clog2(NUM_REQ)).
- State machine:
  - IDLE:
    - No req_valid_i bit set: stay in IDLE.
    - Otherwise select the first set bit scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
    - The winner is registered into grant_o on the next edge; go to LOAD.
  - LOAD:
    - req_ready_o[g] = (state==LOAD) && tx_done_i; this is combinational and only for the granted requester g.
    - On valid&ready, at the next edge: tx_data_o<=data[g]; tx_start_o<=1; last_q<=req_last_i[g]; go to WAIT_ACK.
    - Granted requester not valid: stay in LOAD with the grant held. This lock is what keeps messages from interleaving.
  - WAIT_ACK:
    - tx_start_o returns to 0 after exactly one cycle high.
    - Stay until tx_done_i==0, then go to WAIT_DONE.
  - WAIT_DONE:
    - Stay until tx_done_i==1.
    - If last_q==1: grant_o<=0; rr_ptr<=(g+1) mod NUM_REQ; go to IDLE.
    - If last_q==0: go to LOAD.
- Never assert tx_start_o while tx_done_i is low. After reset, the first start waits for tx_done_i high.
- Latency: request in IDLE -> grant after 1 cycle -> ready in the same cycle if tx_done_i is high -> tx_start_o 1 cycle after acceptance.
- Simultaneous requests: strict round-robin from rr_ptr. A requester that just finished has the lowest priority next round.
- Non-granted requests stay pending; their ready stays 0. Non-granted valid/data changes are ignored.
- NUM_REQ=1: behaves as a packetising pass-through; rr_ptr stays 0.
- A single-byte message has req_last_i=1 on its first byte; the grant is released after that one byte.

Optional Feature:
Macro UART_ARB_TIMEOUT_EN.
- Defined:
  - Adds output timeout_o (1 bit, reset 0) and a stall counter.
  - The counter is cleared on entry to LOAD and on every accepted byte, and increments each LOAD cycle while req_valid_i[g]==0.
  - When it reaches TIMEOUT_CYCLES-1: pulse timeout_o for 1 cycle, clear grant_o, advance rr_ptr past g, go to IDLE.
  - The counter never runs in WAIT_ACK or WAIT_DONE.
- Not defined: no timeout_o port, no counter; the grant is held indefinitely in LOAD.

Test Plan:
- Single requester, NUM_REQ=4: req 2 sends 0x41,0x42 (last on 0x42) with a transmitter model (done drops 1 cycle after start, rises 100 cycles later) -> exactly two tx_start_o pulses carrying 0x41 then 0x42; grant_o=4'b0100 throughout; grant_o=0 after the second done rise.
- Contention: reqs 0,1,3 valid together at rr_ptr=0, each with a 3-byte message -> wire order 0,0,0,1,1,1,3,3,3; no interleaving; rr_ptr=0 after the round.
- Fairness: req 0 re-requests immediately after finishing while req 1 is waiting -> req 1 is granted next.
- Stall: granted req 1 drops valid for 50 cycles mid-message while req 2 is valid (macro off) -> grant stays 4'b0010 and no tx_start_o pulses; the message resumes and completes before req 2 is granted.
- Reset mid-message: deassert rst_n during WAIT_DONE with tx_done_i low -> all outputs 0 at once. After release with req 0 valid, ready and start stay low until tx_done_i=1.
- UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16: granted req 0 stalls in LOAD -> timeout_o pulses after 16 LOAD cycles; the next grant goes to req 1.
